iafu_axi4_traffic_gen: RTL and testbench
========================================

IAFU_AXI4_TRAFFIC_GEN -- requirements
Module: iafu_axi4_traffic_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_LINES  16  number of 64-byte lines written then read back (1..65535)
  BASE_ADDR  64'h0  first line byte address, 64-byte aligned
  SEED  32'h1  data-pattern seed
  TIMEOUT  1024  max cycles waiting for any single handshake or response
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  refclk  in  1  sole clock, all logic rising-edge
  ip2hdm_reset_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse, begins a test run
  mc2ip_memsize_s  in  cxlip_top_pkg::MEMSIZE_WIDTH  memory size in bytes
  iafu2mc_to_mc_axi4  out  mc_axi_if_pkg::t_to_mc_axi4  AXI4 request channels (AW, W, AR, bready, rready)
  mc2iafu_from_mc_axi4  in  mc_axi_if_pkg::t_from_mc_axi4  AXI4 response channels (ready signals, B, R)
  busy  out  1  run in progress
  done  out  1  sticky run-complete flag
  pass  out  1  done with zero errors and no timeout
  timeout  out  1  sticky, run aborted by watchdog
  err_count  out  16  saturating error count

Function
REQ-003 The block SHALL be the AXI4 initiator toward the memory controller, with at most one outstanding transaction.
REQ-004 All requests SHALL use ID 0, len 0 (single beat), size 3'd6 (64 B), burst INCR, wstrb all ones, wlast 1, and all other request fields 0.
REQ-005 Line i (0..NUM_LINES-1) SHALL use address BASE_ADDR + 64*i.
REQ-006 Line i data SHALL be 8 64-bit words; word k = {i[31:0], SEED ^ k}.
REQ-007 FSM states: IDLE, CHECK, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE.
REQ-008 IDLE: on start, clear done/pass/timeout/err_count, set line index 0, go to CHECK; start is ignored in every other state.
REQ-009 CHECK (1 cycle): if BASE_ADDR + 64*NUM_LINES > mc2ip_memsize_s, set err_count 1 and go to DONE; else go to WR_REQ.
REQ-010 WR_REQ: awvalid and wvalid SHALL assert together on entry; each SHALL deassert on the cycle after its own valid&ready handshake; the FSM SHALL go to WR_RSP once both have completed, in either order or the same cycle.
REQ-011 WR_RSP: bready SHALL be 1; on bvalid, increment err_count if bresp != 0 or bid != 0; then go to WR_REQ for the next line, or to RD_REQ with index 0 after the last line.
REQ-012 RD_REQ: arvalid SHALL be held with stable payload until arready, then the FSM SHALL go to RD_RSP.
REQ-013 RD_RSP: rready SHALL be 1; on rvalid, increment err_count once if rresp != 0, rid != 0, rlast != 1, or rdata != the REQ-006 pattern; then go to RD_REQ for the next line, or to DONE after the last line.
REQ-014 Valid signals SHALL NOT deassert before their handshake, and payload SHALL stay stable while valid is high.
REQ-015 Watchdog: a 16-bit counter SHALL clear on every state change and increment each cycle in WR_REQ, WR_RSP, RD_REQ and RD_RSP.
REQ-016 When the watchdog reaches TIMEOUT, the block SHALL set timeout, increment err_count, drop all valids and readies, and go to DONE.
REQ-017 err_count SHALL saturate at 16'hFFFF.
REQ-018 DONE: set done, and set pass = (err_count==0 && !timeout); busy SHALL be 0 in IDLE and DONE and 1 otherwise.
REQ-019 DONE SHALL go to IDLE on the next cycle, with done, pass, timeout and err_count held until the next start.

Reset
REQ-020 While ip2hdm_reset_n is low, the FSM SHALL be IDLE and all valids, readies, busy, done, pass, timeout and err_count SHALL be 0, asynchronously.
REQ-021 A reset asserted mid-run SHALL abandon the run with no further AXI activity after deassertion until a new start.

Verification
REQ-022 NUM_LINES=4, zero-wait responder model -> 4 writes then 4 reads to 0x0/0x40/0x80/0xC0, done=1, pass=1, err_count=0.
REQ-023 Responder with random ready/valid stalls (0-5 cycles) and awready before or after wready -> identical results, valid/payload stable under stall.
REQ-024 Responder corrupts rdata bit 0 of line 2 and returns bresp=2 on line 1 -> err_count=2, pass=0.
REQ-025 memsize=0x80 with NUM_LINES=4 -> no AXI traffic, done=1, err_count=1, pass=0.
REQ-026 Responder never asserts bvalid, TIMEOUT=16 -> timeout=1, err_count=1, done within 16+3 cycles of bready rising.
REQ-027 Reset pulsed during RD_RSP, then start -> outputs 0 during reset, and the fresh run passes.

Source files
------------

// File: rtl/cxlip_top_pkg.sv
// Top-level sizing constants shared by the CXL IP and its attached accelerator logic.
package cxlip_top_pkg;
  parameter int MEMSIZE_WIDTH = 64;
endpackage

// File: rtl/mc_axi_if_pkg.sv
// AXI4 request/response bundles between the accelerator and the memory controller.
package mc_axi_if_pkg;
  typedef struct packed {
    logic [7:0]   awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [2:0]   awprot;
    logic [3:0]   awqos;
    logic [3:0]   awcache;
    logic         awlock;
    logic         awvalid;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         bready;
    logic [7:0]   arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic [3:0]   arcache;
    logic         arlock;
    logic         arvalid;
    logic         rready;
  } t_to_mc_axi4;

  typedef struct packed {
    logic         awready;
    logic         wready;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         arready;
    logic [7:0]   rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
  } t_from_mc_axi4;
endpackage

// File: rtl/iafu_axi4_traffic_gen.sv
// Writes NUM_LINES patterned 64 B lines to the memory controller, reads them back and checks them.
// One transaction outstanding; every handshake/response wait is bounded by a TIMEOUT-cycle watchdog.
module iafu_axi4_traffic_gen
  import mc_axi_if_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter logic [31:0] SEED      = 32'h1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                                     refclk,
  input  logic                                     ip2hdm_reset_n,
  input  logic                                     start,
  input  logic [cxlip_top_pkg::MEMSIZE_WIDTH-1:0]  mc2ip_memsize_s,
  output mc_axi_if_pkg::t_to_mc_axi4               iafu2mc_to_mc_axi4,
  input  mc_axi_if_pkg::t_from_mc_axi4             mc2iafu_from_mc_axi4,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     pass,
  output logic                                     timeout,
  output logic [15:0]                              err_count
);
  typedef enum logic [2:0] {IDLE, CHECK, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_LINES - 1);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);
  localparam logic [64:0] END_ADDR = {1'b0, BASE_ADDR} + (65'(NUM_LINES) << 6);

  state_t        state, state_nxt;
  logic [15:0]   idx;
  logic [15:0]   wdog;
  logic          aw_ok, w_ok;
  logic [63:0]   line_addr;
  logic [511:0]  line_data;
  logic          last, overflow, wd_run, wd_hit, aw_fin, w_fin, b_bad, r_bad, err_inc;
  t_from_mc_axi4 rsp;
  t_to_mc_axi4   req;

  assign rsp       = mc2iafu_from_mc_axi4;
  assign line_addr = BASE_ADDR + {42'b0, idx, 6'b0};

  always_comb begin
    line_data = '0;
    for (int k = 0; k < 8; k++) line_data[64*k +: 64] = {16'b0, idx, SEED ^ 32'(k)};
  end

  assign last     = (idx == LAST_IDX);
  assign overflow = END_ADDR > 65'(mc2ip_memsize_s);
  assign wd_run   = (state == WR_REQ) || (state == WR_RSP) || (state == RD_REQ) || (state == RD_RSP);
  assign wd_hit   = wd_run && (wdog == WD_LIMIT);
  // A channel already handshaken stays complete even though its valid has dropped.
  assign aw_fin   = aw_ok || rsp.awready;
  assign w_fin    = w_ok || rsp.wready;
  assign b_bad    = (rsp.bresp != 2'd0) || (rsp.bid != 8'd0);
  assign r_bad    = (rsp.rresp != 2'd0) || (rsp.rid != 8'd0) || !rsp.rlast || (rsp.rdata != line_data);
  assign err_inc  = wd_hit ||
                    ((state == WR_RSP) && rsp.bvalid && b_bad) ||
                    ((state == RD_RSP) && rsp.rvalid && r_bad);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = overflow ? DONE : WR_REQ;
      WR_REQ:  if (aw_fin && w_fin) state_nxt = WR_RSP;
      WR_RSP:  if (rsp.bvalid) state_nxt = last ? RD_REQ : WR_REQ;
      RD_REQ:  if (rsp.arready) state_nxt = RD_RSP;
      RD_RSP:  if (rsp.rvalid) state_nxt = last ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (wd_hit) state_nxt = DONE;
  end

  always_ff @(posedge refclk or negedge ip2hdm_reset_n) begin
    if (!ip2hdm_reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      wdog      <= '0;
      aw_ok     <= 1'b0;
      w_ok      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wdog <= '0;
      else if (wd_run)        wdog <= wdog + 16'd1;
      if (state != WR_REQ) begin
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end else begin
        if (rsp.awready) aw_ok <= 1'b1;
        if (rsp.wready)  w_ok  <= 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          done      <= 1'b0;
          pass      <= 1'b0;
          timeout   <= 1'b0;
          err_count <= '0;
          idx       <= '0;
        end
        CHECK:  if (overflow) err_count <= 16'd1;
        WR_RSP: if (rsp.bvalid && !wd_hit) idx <= last ? 16'd0 : idx + 16'd1;
        RD_RSP: if (rsp.rvalid && !wd_hit) idx <= idx + 16'd1;
        DONE: begin
          done <= 1'b1;
          pass <= (err_count == 16'd0) && !timeout;
        end
        default: ;
      endcase
      if (wd_hit) timeout <= 1'b1;
      if (err_inc && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

  // Valids and readies decode straight from state, so reset and DONE silence the bus at once.
  always_comb begin
    req         = '0;
    req.awaddr  = line_addr;
    req.awsize  = 3'd6;
    req.awburst = 2'b01;
    req.awvalid = (state == WR_REQ) && !aw_ok;
    req.wdata   = line_data;
    req.wstrb   = '1;
    req.wlast   = 1'b1;
    req.wvalid  = (state == WR_REQ) && !w_ok;
    req.bready  = (state == WR_RSP);
    req.araddr  = line_addr;
    req.arsize  = 3'd6;
    req.arburst = 2'b01;
    req.arvalid = (state == RD_REQ);
    req.rready  = (state == RD_RSP);
  end

  assign iafu2mc_to_mc_axi4 = req;
  assign busy = (state != IDLE) && (state != DONE);
endmodule

// File: tb/tb_iafu_axi4_traffic_gen.sv
// Directed bench: AXI4 memory responder with optional stalls, error injection and a silent B channel.
module tb_iafu_axi4_traffic_gen;
  import mc_axi_if_pkg::*;

  localparam int          NL     = 4;
  localparam logic [31:0] SEED_P = 32'hCAFE_0001;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] memsize;
  t_to_mc_axi4   req;
  t_from_mc_axi4 rsp;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit stall, corrupt, no_b;

  iafu_axi4_traffic_gen #(
    .NUM_LINES(NL), .BASE_ADDR(64'h0), .SEED(SEED_P), .TIMEOUT(16)
  ) dut (
    .refclk(refclk), .ip2hdm_reset_n(rst_n), .start(start), .mc2ip_memsize_s(memsize),
    .iafu2mc_to_mc_axi4(req), .mc2iafu_from_mc_axi4(rsp),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int line);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = {32'(line), SEED_P ^ 32'(k)};
    return d;
  endfunction

  function automatic int rnd();
    return stall ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // Responder: inputs change on the falling edge; handshakes are those seen at the previous rising edge.
  t_to_mc_axi4   p_req;
  t_from_mc_axi4 p_rsp;
  logic [511:0]  mem [4];
  logic [63:0]   aw_q, r_q;
  logic [511:0]  w_q;
  bit            aw_got, w_got, b_pend, r_pend, any_vld;
  bit            hs_aw, hs_w, hs_b, hs_ar, hs_r;
  int            aw_n, w_n, b_n, ar_n;
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

  always @(negedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp = '0; p_req = '0; p_rsp = '0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; any_vld = 0;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      hs_aw = p_req.awvalid && p_rsp.awready;
      hs_w  = p_req.wvalid && p_rsp.wready;
      hs_b  = p_rsp.bvalid && p_req.bready;
      hs_ar = p_req.arvalid && p_rsp.arready;
      hs_r  = p_rsp.rvalid && p_req.rready;
      if (req.awvalid || req.wvalid || req.arvalid) any_vld = 1;

      if (p_req.awvalid && !p_rsp.awready)
        chk("aw_hold", 64'(req.awvalid && req.awaddr == p_req.awaddr), 64'd1);
      if (p_req.wvalid && !p_rsp.wready)
        chk("w_hold", 64'(req.wvalid && req.wdata == p_req.wdata), 64'd1);
      if (p_req.arvalid && !p_rsp.arready)
        chk("ar_hold", 64'(req.arvalid && req.araddr == p_req.araddr), 64'd1);

      if (hs_aw) begin
        chk("awaddr", p_req.awaddr, 64'(aw_n) << 6);
        chk("aw_fmt", 64'({p_req.awid, p_req.awlen, p_req.awsize, p_req.awburst, p_req.awprot, p_req.awcache, p_req.awlock}),
            64'({8'd0, 8'd0, 3'd6, 2'd1, 3'd0, 4'd0, 1'b0}));
        aw_q = p_req.awaddr; aw_got = 1; aw_n++;
        rsp.awready = 0; aw_cnt = rnd();
      end else if (req.awvalid && !rsp.awready) begin
        if (aw_cnt == 0) rsp.awready = 1; else aw_cnt--;
      end

      if (hs_w) begin
        chk("wdata", 64'(p_req.wdata == pat(w_n)), 64'd1);
        chk("w_fmt", 64'({p_req.wlast, &p_req.wstrb}), 64'd3);
        w_q = p_req.wdata; w_got = 1; w_n++;
        rsp.wready = 0; w_cnt = rnd();
      end else if (req.wvalid && !rsp.wready) begin
        if (w_cnt == 0) rsp.wready = 1; else w_cnt--;
      end

      if (aw_got && w_got) begin
        mem[aw_q[7:6]] = w_q;
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = rnd();
      end
      if (hs_b) rsp.bvalid = 0;
      if (b_pend && !rsp.bvalid && !no_b) begin
        if (b_cnt == 0) begin
          rsp.bvalid = 1; rsp.bid = 8'd0;
          rsp.bresp = (corrupt && b_n == 1) ? 2'd2 : 2'd0;
          b_n++; b_pend = 0;
        end else b_cnt--;
      end

      if (hs_ar) begin
        chk("araddr", p_req.araddr, 64'(ar_n) << 6);
        chk("wr_before_rd", 64'(aw_n), 64'(NL));
        r_q = p_req.araddr; r_pend = 1; r_cnt = rnd(); ar_n++;
        rsp.arready = 0; ar_cnt = rnd();
      end else if (req.arvalid && !rsp.arready) begin
        if (ar_cnt == 0) rsp.arready = 1; else ar_cnt--;
      end

      if (hs_r) rsp.rvalid = 0;
      if (r_pend && !rsp.rvalid) begin
        if (r_cnt == 0) begin
          rsp.rvalid = 1; rsp.rid = 8'd0; rsp.rresp = 2'd0; rsp.rlast = 1;
          rsp.rdata = mem[r_q[7:6]];
          if (corrupt && r_q[7:6] == 2'd2) rsp.rdata[0] = ~rsp.rdata[0];
          r_pend = 0;
        end else r_cnt--;
      end
      p_req = req; p_rsp = rsp;
    end
  end

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge refclk);
    rst_n = 1;
    @(negedge refclk);
  endtask

  task automatic run(input string tag);
    start = 1;
    @(negedge refclk);
    start = 0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < 600 && !done; i++) @(negedge refclk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic expect_res(input string tag, input logic p, input logic t, input logic [15:0] e);
    chk({tag, "_pass"}, 64'(pass), 64'(p));
    chk({tag, "_timeout"}, 64'(timeout), 64'(t));
    chk({tag, "_err"}, 64'(err_count), 64'(e));
  endtask

  initial begin
    int t0, n;
    rst_n = 0; start = 0; memsize = 64'h1_0000;
    stall = 0; corrupt = 0; no_b = 0;
    #1;
    chk("rst_flags", 64'({busy, done, pass, timeout}), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_bus", 64'({req.awvalid, req.wvalid, req.bready, req.arvalid, req.rready}), 64'd0);
    @(negedge refclk);
    rst_n = 1;
    @(negedge refclk);

    run("zw");
    expect_res("zw", 1'b1, 1'b0, 16'd0);
    chk("zw_writes", 64'(aw_n), 64'd4);
    chk("zw_reads", 64'(ar_n), 64'd4);
    repeat (5) @(negedge refclk);
    chk("zw_hold", 64'({done, pass}), 64'd3);

    do_reset();
    stall = 1;
    run("stall");
    expect_res("stall", 1'b1, 1'b0, 16'd0);
    chk("stall_reads", 64'(ar_n), 64'd4);

    do_reset();
    stall = 0; corrupt = 1;
    run("bad");
    expect_res("bad", 1'b0, 1'b0, 16'd2);
    corrupt = 0;

    do_reset();
    memsize = 64'h80;
    run("mem");
    expect_res("mem", 1'b0, 1'b0, 16'd1);
    chk("mem_no_traffic", 64'(any_vld), 64'd0);
    memsize = 64'h1_0000;

    do_reset();
    no_b = 1;
    start = 1;
    @(negedge refclk);
    start = 0;
    n = 0;
    while (!req.bready && n < 100) begin @(negedge refclk); n++; end
    chk("to_bready", 64'(req.bready), 64'd1);
    t0 = cyc;
    n = 0;
    while (!done && n < 60) begin @(negedge refclk); n++; end
    chk("to_done", 64'(done), 64'd1);
    chk("to_latency", 64'((cyc - t0) >= 16 && (cyc - t0) <= 19), 64'd1);
    expect_res("to", 1'b0, 1'b1, 16'd1);
    chk("to_quiet", 64'({req.bready, req.awvalid, req.wvalid}), 64'd0);
    no_b = 0;

    do_reset();
    start = 1;
    @(negedge refclk);
    start = 0;
    n = 0;
    while (!req.rready && n < 200) begin @(negedge refclk); n++; end
    chk("mid_rd_rsp", 64'(req.rready), 64'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_flags", 64'({busy, done, pass, timeout}), 64'd0);
    chk("mid_rst_err", 64'(err_count), 64'd0);
    chk("mid_rst_bus", 64'({req.awvalid, req.wvalid, req.bready, req.arvalid, req.rready}), 64'd0);
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1;
    repeat (10) @(negedge refclk);
    chk("post_rst_quiet", 64'(any_vld), 64'd0);
    run("fresh");
    expect_res("fresh", 1'b1, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "simulation did not finish");
  end
endmodule
